// File: rtl/gf8_inner_product_seq.sv
// Sequential GF(2^8) inner product: P lanes per beat, N/P beats per vector,
// valid/ready in and out, with synchronous abort.
module gf8_inner_product_seq #(
  parameter int          N    = 8,
  parameter int          P    = 2,
  parameter logic [7:0]  POLY = 8'h1B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P*8-1:0]   x_beat,
  input  logic [P*8-1:0]   y_beat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       xy
);

  localparam int BEATS = N / P;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if (N < 1 || P < 1 || P > N || (N % P) != 0) begin : g_param_chk
    $error("gf8_inner_product_seq: need 1 <= P <= N and N %% P == 0");
  end

  typedef enum logic {
    ACC,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    partial;
  logic          beat_ok;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] aa;
    logic [7:0] r;
    aa = a;
    r  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? POLY : 8'h00);
    end
    return r;
  endfunction

  always_comb begin
    partial = 8'h00;
    for (int k = 0; k < P; k++) begin
      partial = partial ^ gf_mul(x_beat[8*k +: 8], y_beat[8*k +: 8]);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    in_ready  = (state_q == ACC);
    out_valid = (state_q == HOLD);
    xy        = acc_q;
    beat_ok   = in_valid && in_ready;

    unique case (state_q)
      ACC: begin
        if (beat_ok) begin
          acc_d = (cnt_q == '0) ? partial : (acc_q ^ partial);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase

    // Abort wins over any handshake taken in the same cycle.
    if (abort) begin
      state_d = ACC;
      cnt_d   = '0;
      acc_d   = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_gf8_inner_product_seq.sv
// Directed bench: P=2 main engine, P=1 and P=8 copies fed the same vectors.
// Index 0 -> P=1, index 1 -> P=2, index 2 -> P=8.
module tb_gf8_inner_product_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] ivs = 3'b000;
  logic [2:0] irs;
  logic [2:0] ovs;
  logic [7:0] xys [3];
  logic [7:0]  x1 = '0, y1 = '0;
  logic [15:0] x2 = '0, y2 = '0;
  logic [63:0] x8 = '0, y8 = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit mon = 1'b0;
  logic [7:0] mq [$];
  int         cq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon && ovs[1] && out_ready) begin
      mq.push_back(xys[1]);
      cq.push_back(cyc);
    end
  end

  gf8_inner_product_seq #(.N(8), .P(1), .POLY(8'h1B)) u_p1 (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(ivs[0]), .in_ready(irs[0]),
    .x_beat(x1), .y_beat(y1),
    .out_valid(ovs[0]), .out_ready(out_ready), .xy(xys[0])
  );

  gf8_inner_product_seq #(.N(8), .P(2), .POLY(8'h1B)) u_p2 (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(ivs[1]), .in_ready(irs[1]),
    .x_beat(x2), .y_beat(y2),
    .out_valid(ovs[1]), .out_ready(out_ready), .xy(xys[1])
  );

  gf8_inner_product_seq #(.N(8), .P(8), .POLY(8'h1B)) u_p8 (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(ivs[2]), .in_ready(irs[2]),
    .x_beat(x8), .y_beat(y8),
    .out_valid(ovs[2]), .out_ready(out_ready), .xy(xys[2])
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input int d, input logic [63:0] xb, input logic [63:0] yb);
    ivs[d] = 1'b1;
    x1 = xb[7:0];  y1 = yb[7:0];
    x2 = xb[15:0]; y2 = yb[15:0];
    x8 = xb;       y8 = yb;
    for (int g = 0; g < 20 && !irs[d]; g++) tick(1);
    if (!irs[d]) check("beat_timeout", 32'(irs[d]), 32'd1);
    tick(1);
    ivs[d] = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; x8 = '0; y8 = '0;
  endtask

  task automatic vec(input int d, input logic [63:0] xv, input logic [63:0] yv);
    int nb;
    int w;
    nb = (d == 0) ? 8 : (d == 1) ? 4 : 1;
    w  = (d == 0) ? 8 : (d == 1) ? 16 : 64;
    for (int b = 0; b < nb; b++) beat(d, xv >> (w * b), yv >> (w * b));
  endtask

  task automatic pop(input int d, input logic [7:0] exp, input string tag);
    check({tag, "_ov"}, 32'(ovs[d]), 32'd1);
    check({tag, "_xy"}, 32'(xys[d]), 32'(exp));
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, 32'(ovs[d]), 32'd0);
    check({tag, "_ir"}, 32'(irs[d]), 32'd1);
  endtask

  // byte i of a vector lives in bits [8i+7:8i]
  localparam logic [63:0] XA = 64'h0000_0000_0000_0057;
  localparam logic [63:0] YA = 64'h0000_0000_0000_0083;
  localparam logic [63:0] XC = 64'h5300_0000_0000_0057;
  localparam logic [63:0] YC = 64'hCA00_0000_0000_0083;
  localparam logic [63:0] XS = 64'h0000_0000_0200_0000;
  localparam logic [63:0] YS = 64'h0000_0000_8700_0000;
  localparam logic [63:0] XI = 64'h5300_0000_0000_0000;
  localparam logic [63:0] YI = 64'hCA00_0000_0000_0000;

  initial begin
    logic [63:0] xa;
    logic [63:0] ya;
    xa = XA;
    ya = YA;

    tick(2);
    rst_n = 1'b1;
    check("rst_ov", 32'(ovs[1]), 32'd0);
    check("rst_xy", 32'(xys[1]), 32'h00);
    check("rst_ir", 32'(irs[1]), 32'd1);

    // basic vector, latency and HOLD behaviour
    for (int b = 0; b < 3; b++) begin
      beat(1, xa >> (16 * b), ya >> (16 * b));
      check("acc_ov_low", 32'(ovs[1]), 32'd0);
    end
    beat(1, xa >> 48, ya >> 48);
    check("hold_ir", 32'(irs[1]), 32'd0);
    pop(1, 8'hC1, "basic");

    vec(1, XC, YC);
    pop(1, 8'hC0, "accum");
    vec(1, XS, YS);
    pop(1, 8'h15, "single");

    // bubbles 1,0,1,0,1,1 then 5 cycles of backpressure
    beat(1, xa, ya);
    tick(1);
    beat(1, 64'h0, 64'h0);
    tick(1);
    beat(1, 64'h0, 64'h0);
    beat(1, 64'h0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      ivs[1] = 1'b1;
      x2 = 16'($urandom);
      y2 = 16'($urandom);
      check("bp_ov", 32'(ovs[1]), 32'd1);
      check("bp_xy", 32'(xys[1]), 32'hC1);
      tick(1);
    end
    out_ready = 1'b1;
    check("bp_hs_xy", 32'(xys[1]), 32'hC1);
    tick(1);
    ivs[1] = 1'b0;
    out_ready = 1'b0;
    check("bp_ir", 32'(irs[1]), 32'd1);
    check("bp_ov_clr", 32'(ovs[1]), 32'd0);
    vec(1, XS, YS);
    pop(1, 8'h15, "after_hold_noise");

    // back-to-back with out_ready held high
    mon = 1'b1;
    out_ready = 1'b1;
    vec(1, XA, YA);
    vec(1, XI, YI);
    tick(3);
    out_ready = 1'b0;
    mon = 1'b0;
    check("b2b_count", 32'(mq.size()), 32'd2);
    if (mq.size() == 2) begin
      check("b2b_first", 32'(mq[0]), 32'hC1);
      check("b2b_second", 32'(mq[1]), 32'h01);
      check("b2b_gap", 32'(cq[1] - cq[0]), 32'd5);
    end

    // reset mid-vector
    beat(1, 64'h0000_0000_0000_0011, 64'h0000_0000_0000_0022);
    beat(1, 64'h0000_0000_0000_0033, 64'h0000_0000_0000_0044);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("mrst_ov", 32'(ovs[1]), 32'd0);
    check("mrst_xy", 32'(xys[1]), 32'h00);
    check("mrst_ir", 32'(irs[1]), 32'd1);
    vec(1, XA, YA);
    pop(1, 8'hC1, "post_rst");

    // abort after one beat; the beat in the abort cycle is dropped
    beat(1, 64'h0000_0000_0000_0557, 64'h0000_0000_0000_0783);
    abort = 1'b1;
    ivs[1] = 1'b1;
    x2 = 16'h0357;
    y2 = 16'h0283;
    tick(1);
    abort = 1'b0;
    ivs[1] = 1'b0;
    check("abt_acc_ov", 32'(ovs[1]), 32'd0);
    check("abt_acc_ir", 32'(irs[1]), 32'd1);
    check("abt_acc_xy", 32'(xys[1]), 32'h00);
    vec(1, XA, YA);
    pop(1, 8'hC1, "post_abt_acc");

    // abort in HOLD
    vec(1, XS, YS);
    check("abt_hold_pre", 32'(ovs[1]), 32'd1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abt_hold_ov", 32'(ovs[1]), 32'd0);
    check("abt_hold_ir", 32'(irs[1]), 32'd1);
    check("abt_hold_xy", 32'(xys[1]), 32'h00);
    vec(1, XC, YC);
    pop(1, 8'hC0, "post_abt_hold");

    // abort coinciding with output handshake
    vec(1, XA, YA);
    abort = 1'b1;
    out_ready = 1'b1;
    tick(1);
    abort = 1'b0;
    out_ready = 1'b0;
    check("abt_hs_ov", 32'(ovs[1]), 32'd0);
    check("abt_hs_xy", 32'(xys[1]), 32'h00);
    vec(1, XS, YS);
    pop(1, 8'h15, "post_abt_hs");

    // P=1 and P=8 engines on the same vectors
    vec(0, XA, YA);
    pop(0, 8'hC1, "p1_basic");
    vec(0, XC, YC);
    pop(0, 8'hC0, "p1_accum");
    vec(0, XS, YS);
    pop(0, 8'h15, "p1_single");
    vec(2, XA, YA);
    pop(2, 8'hC1, "p8_basic");
    vec(2, XC, YC);
    pop(2, 8'hC0, "p8_accum");
    vec(2, XS, YS);
    pop(2, 8'h15, "p8_single");
    vec(2, XI, YI);
    pop(2, 8'h01, "p8_inverse");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gf8_inner_product_seq.md
Name: gf8_inner_product_seq

Overview:
- Sequential, parametrised GF(2^8) inner-product engine for the IPM datapath; computes xy = XOR over i of x[i]·y[i] for vectors of N bytes.
- Consumes P byte-lanes per beat over N/P beats through a valid/ready input stream.
- Holds the byte result on a valid/ready output stream.
- Successor to the fully combinational inner product: lane count and field polynomial are configurable, input and output are back-pressured, and a vector can be aborted.

Parameters:
- N, 8, vector length in bytes; N >= 1.
- P, 2, bytes (lanes) consumed per beat; 1 <= P <= N and N % P == 0, otherwise elaboration error.
- POLY, 8'h1B, low 8 bits of the reduction polynomial (x^8 implied); default is the AES field 0x11B.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- abort  in  1  synchronous discard of the vector in progress.
- in_valid  in  1  x_beat/y_beat valid.
- in_ready  out  1  engine accepts a beat this cycle.
- x_beat  in  P*8  lane k = bits [8k+7:8k] = x[b*P+k] for beat b.
- y_beat  in  P*8  same lane mapping for y.
- out_valid  out  1  xy valid.
- out_ready  in  1  downstream accepts xy.
- xy  out  8  inner-product result.

Behaviour:
- BEATS = N/P; beat counter width = max(1, clog2(BEATS)).
- Per-lane multiply:
  - Combinational GF(2^8) product using POLY.
  - Shift-and-add: 8 iterations of conditional XOR and xtime; xtime = (a<<1) ^ (a[7] ? POLY : 0).
  - Lane products XOR-reduced to partial[7:0].
- States: ACC, HOLD.
- ACC:
  - in_ready=1, out_valid=0.
  - Beat accepted when in_valid & in_ready.
  - On accepted beat: acc <= (cnt==0 ? partial : acc ^ partial), cnt <= cnt+1.
  - If cnt==BEATS-1: acc <= final value, cnt <= 0, state -> HOLD.
  - No accepted beat: acc and cnt hold.
- HOLD:
  - in_ready=0, out_valid=1, xy=acc.
  - x_beat/y_beat/in_valid ignored.
  - On out_valid & out_ready: state -> ACC; in_ready=1 from the next cycle.
  - xy stable while out_ready=0.
- xy is driven from acc in both states and is meaningful only while out_valid=1.
- Latency: out_valid rises the cycle after the last beat is accepted.
  - Peak throughput: one vector per BEATS+1 cycles when out_ready=1.
- Bubbles: in_valid low between beats inserts no error; the result is unaffected.
- abort, in ACC or HOLD:
  - Next cycle: state=ACC, cnt=0, acc=0, out_valid=0.
  - Any beat presented in the abort cycle is dropped.
  - An abort in the same cycle as an output handshake still lands in ACC with cleared state.
- Reset (rst_n=0 at an edge), also mid-vector:
  - state=ACC, cnt=0, acc=0.
  - Output values: out_valid=0, xy=0x00, in_ready=1 after the edge.
  - No partial-vector data survives reset.
- rst_n has priority over abort; abort has priority over handshakes.
- P==N: single-beat vectors, cnt constant 0.
- P==1: N beats.

Test Plan:
- N=8,P=2,POLY=8'h1B: beat0 lane0 x=0x57,y=0x83, all other lanes 0, in_valid=1 for 4 beats -> out_valid=1 the cycle after beat3, xy=0xC1; in_ready=0 while HOLD.
- Accumulation: beat0 lane0 (0x57,0x83), beat3 lane1 (0x53,0xCA), others 0 -> xy=0xC0; single-product check lane1 beat1 (0x02,0x87) alone -> xy=0x15.
- Backpressure and bubbles: in_valid toggled 1,0,1,0,1,1 across the 4 beats, out_ready=0 for 5 cycles -> out_valid held 5 cycles, xy constant 0xC1; random x_beat during HOLD has no effect; handshake in cycle 6 -> in_ready=1 the next cycle.
- Back-to-back: two vectors (first ->0xC1, second all-zero except (0x53,0xCA) ->0x01), out_ready=1 constant -> results 0xC1 then 0x01, the second out_valid exactly 5 cycles after the first.
- Reset mid-vector: rst_n=0 for 1 cycle after 2 beats -> out_valid=0, xy=0x00, in_ready=1; the following full vector (0x57,0x83) -> xy=0xC1, no residue from the old beats.
- Abort: abort=1 after 1 beat of nonzero data, and abort during HOLD -> both return to ACC with out_valid=0; next vector computes correctly. Repeat P=1 and P=8 with the same vectors -> identical xy.
